// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, types and the write-back request record
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_X0 = 0;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting one past the pointer
module rr_arbiter #(
  parameter int N = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] c;
  always_comb begin
    grant = '0;
    idx = '0;
    c = '0;
    for (int k = N; k >= 1; k--) begin
      c = PW'((int'(ptr) + k) % N);
      if (valid[c]) begin
        grant = '0;
        grant[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back port sharing with a pending-write scoreboard
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic [ADDR_W-1:0]         qry_addr_a,
  input  logic [ADDR_W-1:0]         qry_addr_b,
  output logic                      qry_busy_a,
  output logic                      qry_busy_b,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      err_unreserved
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int NR = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);
  logic [PW-1:0] rr_ptr, g;
  logic [NUM_REQ-1:0] grant;
  logic [NR-1:0] busy, busy_nxt;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic hs, wb;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .valid(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(g)
  );
  assign req_ready = rst_n ? grant : '0;
  assign hs = |(req_valid & req_ready);
  assign a = req_addr[int'(g)*ADDR_W +: ADDR_W];
  assign d = req_data[int'(g)*DATA_W +: DATA_W];
  assign wb = hs && a != X0;
  assign qry_busy_a = busy[qry_addr_a];
  assign qry_busy_b = busy[qry_addr_b];
  always_comb begin
    busy_nxt = busy;
    if (wb) busy_nxt[a] = 1'b0;
    if (rsv_valid && rsv_addr != X0) busy_nxt[rsv_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PW'(NUM_REQ - 1);
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      err_unreserved <= 1'b0;
      busy <= '0;
    end else begin
      if (hs) rr_ptr <= g;
      wr_en <= wb;
      if (wb) begin
        wr_addr <= a;
        wr_data <= d;
      end
      if (wb && !busy[a]) err_unreserved <= 1'b1;
      busy <= busy_nxt;
    end
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between N write-back requesters (ALU, load unit, mul/div).
- Requesters are served round-robin with a valid/ready handshake.
- Keeps a destination-register scoreboard so the issue stage can stall on pending writes.
- Sits between the execute/memory units and the 32x32 register file; drives its regWrite / regAddrWrite / regWriteData inputs.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8).
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (32 registers, x0 hard-wired zero).

Ports:
- clk  in  1  system clock (100 MHz), rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a write-back pending.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready.
- req_addr  in  NUM_REQ*ADDR_W  flattened destination addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  flattened write data; same packing.
- rsv_valid  in  1  issue stage reserves destination rsv_addr this cycle.
- rsv_addr  in  ADDR_W  register being reserved.
- qry_addr_a  in  ADDR_W  issue-stage source A.
- qry_addr_b  in  ADDR_W  issue-stage source B.
- qry_busy_a  out  1  source A has a pending write (combinational from scoreboard).
- qry_busy_b  out  1  source B has a pending write.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  ADDR_W  register-file write address (registered).
- wr_data  out  DATA_W  register-file write data (registered).
- err_unreserved  out  1  sticky: a write-back targeted a non-busy, non-zero register.

Behaviour:
- Reset (rst_n low, asynchronous): wr_en=0, wr_addr=0, wr_data=0, err_unreserved=0, scoreboard all 0, rr_ptr=NUM_REQ-1. req_ready=0 while in reset.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr+1 mod NUM_REQ; the first set bit wins.
  - req_ready is one-hot on the winner; all zero if no valid.
  - A requester may drop valid at any time before its handshake.
- On handshake of requester g:
  - rr_ptr<=g.
  - Next cycle: wr_en=1, wr_addr=req_addr[g], wr_data=req_data[g]. Latency from handshake to write strobe is 1 cycle.
  - Throughput is one write per cycle.
- Handshake with addr==0: accepted and rr_ptr advances, but wr_en stays 0 next cycle. The x0 scoreboard bit is never set.
- No handshake: wr_en=0 next cycle; wr_addr/wr_data hold their previous values.
- Scoreboard (busy[31:0]):
  - rsv_valid with rsv_addr!=0 sets busy[rsv_addr].
  - A non-zero write-back handshake clears busy[addr] in the handshake cycle, so the query is not busy one cycle later, matching the register file's write-to-read forwarding.
  - Set and clear of the same register in the same cycle: set wins (new reservation outstanding).
  - Reserving an already-busy register leaves it busy. There is no counting: the issue stage must stall WAW itself using qry_busy.
- qry_busy_x = busy[qry_addr_x]; always 0 for address 0.
- err_unreserved is set when a handshake targets addr!=0 whose busy bit is 0 in that cycle. It stays set until reset.
- Reset mid-operation: any pending wr_en is cancelled immediately and the scoreboard is cleared. Requesters must re-present after reset.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_X0=0.
  - typedef reg_addr_t, typedef reg_data_t.
  - A wb_req_t struct {addr, data}.
- One natural sub-module: rr_arbiter (NUM_REQ-wide round-robin grant with pointer input, combinational).
- Scoreboard and output registers stay in the top module.

Test Plan:
- Single requester: rsv x5, then req1 valid addr=5 data=0xDEADBEEF -> ready1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; qry_busy on x5 goes 1 then 0; err_unreserved=0.
- All three requesters valid continuously (addrs 1,2,3, all reserved) from reset -> grants 0,1,2,0,... one per cycle; wr_addr sequence 1,2,3,1.
- Write-back to x0 with data 0xFFFFFFFF -> ready asserted; wr_en stays 0; busy bits unchanged.
- rsv_valid x7 in the same cycle as a write-back handshake to x7 -> wr_en to x7 next cycle, and qry_busy for x7 stays 1.
- Write-back to unreserved x9 -> write issued normally; err_unreserved=1 and stays 1 until rst_n pulse.
- Assert rst_n=0 asynchronously mid-cycle with wr_en=1 and busy x3,x4 set -> wr_en=0 immediately, all qry_busy=0, grants restart at requester 0.
